// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two data-memory requesters (CPU LSU, AXI-Lite host),
// the arbiter and the single-port BRAM. slave = arbiter view, master = requester/BRAM view.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int STALL_CNT_W = 16
);
  localparam int STRB_W = DATA_W / 8;

  logic                   cpu_req;
  logic                   cpu_we;
  logic [ADDR_W-1:0]      cpu_addr;
  logic [DATA_W-1:0]      cpu_wdata;
  logic [STRB_W-1:0]      cpu_wstrb;
  logic                   cpu_gnt;
  logic                   cpu_rvalid;
  logic [DATA_W-1:0]      cpu_rdata;

  logic                   axi_req;
  logic                   axi_we;
  logic [ADDR_W-1:0]      axi_addr;
  logic [DATA_W-1:0]      axi_wdata;
  logic [STRB_W-1:0]      axi_wstrb;
  logic                   axi_gnt;
  logic                   axi_rvalid;
  logic [DATA_W-1:0]      axi_rdata;

  logic                   axi_lock;
  logic                   lock_ack;

  logic                   mem_en;
  logic [STRB_W-1:0]      mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;

  logic [STALL_CNT_W-1:0] cpu_stall_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  axi_req, axi_we, axi_addr, axi_wdata, axi_wstrb,
    output axi_gnt, axi_rvalid, axi_rdata,
    input  axi_lock,
    output lock_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output cpu_stall_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output axi_req, axi_we, axi_addr, axi_wdata, axi_wstrb,
    input  axi_gnt, axi_rvalid, axi_rdata,
    output axi_lock,
    input  lock_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  cpu_stall_cnt
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin CPU/host arbiter for the shared data-memory BRAM, with a host
// lock mode that drains outstanding CPU reads before granting exclusive access.
module dmem_rd_return #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hit,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);
  // rdata is sticky: it only changes when this requester's next read lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= hit;
      if (hit) rdata <= mem_rdata;
    end
  end
endmodule

module dmem_port_arbiter #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic S_AXI_ACLK,
  input  logic S_AXI_ARESET,
  dmem_port_arbiter_if.slave bus
);
  localparam int STRB_W  = DATA_W / 8;
  localparam int NUM_REQ = 2;   // owner 0 = CPU, owner 1 = host
  localparam int STAGES  = 2;   // command register, BRAM read

  localparam logic [1:0] NORMAL = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } cmd_t;

  logic [1:0]             state, state_nxt;
  logic                   axi_pri;     // 1: host wins the next tie
  logic                   armed;       // low in reset and the release cycle
  logic                   cpu_gnt_c, axi_gnt_c, cpu_xfer, axi_xfer;
  cmd_t                   cpu_cmd, axi_cmd, win_cmd, cmd_q;
  logic                   s1_vld;
  logic [STAGES:0]        rd_pipe, own_pipe;
  logic                   cpu_pend;
  logic [STALL_CNT_W-1:0] stall_cnt;

  logic [NUM_REQ-1:0]             hit, rvalid;
  logic [NUM_REQ-1:0][DATA_W-1:0] rdata;

  assign cpu_cmd = {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata, bus.cpu_wstrb};
  assign axi_cmd = {bus.axi_we, bus.axi_addr, bus.axi_wdata, bus.axi_wstrb};

  // In the cycle the lock request arrives the CPU is already shut out, while the
  // host still competes as if the CPU were in the race.
  always_comb begin
    cpu_gnt_c = 1'b0;
    axi_gnt_c = 1'b0;
    if (armed) begin
      case (state)
        NORMAL: begin
          cpu_gnt_c = bus.cpu_req && !bus.axi_lock && (!bus.axi_req || !axi_pri);
          axi_gnt_c = bus.axi_req && (!bus.cpu_req || axi_pri);
        end
        default: axi_gnt_c = bus.axi_req;
      endcase
    end
  end

  assign cpu_xfer    = bus.cpu_req && cpu_gnt_c;
  assign axi_xfer    = bus.axi_req && axi_gnt_c;
  assign win_cmd     = axi_xfer ? axi_cmd : cpu_cmd;
  assign rd_pipe[0]  = (cpu_xfer || axi_xfer) && !win_cmd.we;
  assign own_pipe[0] = axi_xfer;

  // Drain watches only registered stages; the rvalid stage has already retired
  assign cpu_pend = |(rd_pipe[STAGES:1] & ~own_pipe[STAGES:1]);

  always_comb begin
    state_nxt = state;
    case (state)
      NORMAL:  if (bus.axi_lock) state_nxt = DRAIN;
      DRAIN:   if (!bus.axi_lock) state_nxt = NORMAL;
               else if (!cpu_pend) state_nxt = LOCKED;
      LOCKED:  if (!bus.axi_lock) state_nxt = NORMAL;
      default: state_nxt = NORMAL;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state     <= NORMAL;
      axi_pri   <= 1'b0;
      armed     <= 1'b0;
      s1_vld    <= 1'b0;
      cmd_q     <= '0;
      rd_pipe[STAGES:1]  <= '0;
      own_pipe[STAGES:1] <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (state != NORMAL && state_nxt == NORMAL) axi_pri <= 1'b0;
      else if (cpu_xfer)                          axi_pri <= 1'b1;
      else if (axi_xfer)                          axi_pri <= 1'b0;
      s1_vld <= cpu_xfer || axi_xfer;
      if (cpu_xfer || axi_xfer) cmd_q <= win_cmd;
      rd_pipe[STAGES:1]  <= rd_pipe[STAGES-1:0];
      own_pipe[STAGES:1] <= own_pipe[STAGES-1:0];
      if (bus.cpu_req && !cpu_gnt_c && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ret
    assign hit[g] = rd_pipe[STAGES] && (own_pipe[STAGES] == 1'(g));
    dmem_rd_return #(.DATA_W(DATA_W)) u_ret (
      .clk       (S_AXI_ACLK),
      .rst       (S_AXI_ARESET),
      .hit       (hit[g]),
      .mem_rdata (bus.mem_rdata),
      .rvalid    (rvalid[g]),
      .rdata     (rdata[g])
    );
  end

  assign bus.cpu_gnt       = cpu_gnt_c;
  assign bus.axi_gnt       = axi_gnt_c;
  assign bus.cpu_rvalid    = rvalid[0];
  assign bus.cpu_rdata     = rdata[0];
  assign bus.axi_rvalid    = rvalid[1];
  assign bus.axi_rdata     = rdata[1];
  assign bus.lock_ack      = (state == LOCKED);
  assign bus.mem_en        = s1_vld;
  assign bus.mem_we        = (s1_vld && cmd_q.we) ? cmd_q.wstrb : '0;
  assign bus.mem_addr      = cmd_q.addr;
  assign bus.mem_wdata     = cmd_q.wdata;
  assign bus.cpu_stall_cnt = stall_cnt;
endmodule
